// File: rtl/l1i_axi_read_master.sv
// l1i_axi_read_master
// Read-only AXI4 master for the L1 instruction cache refill port. One cache
// line request becomes one INCR burst of BURST_BEATS 32-bit beats. Each
// accepted R beat is handed back to the cache as a single-cycle I_wait-low
// pulse carrying the beat on I_out.
module l1i_axi_read_master #(
    parameter logic [3:0] AXI_ID      = 4'd0,
    parameter int         BURST_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,

    // Cache refill port
    input  logic        I_req,
    input  logic [31:0] I_addr,
    output logic [31:0] I_out,
    output logic        I_wait,

    // AXI read-address channel
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,

    // AXI read-data channel
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,

    // Sticky error flag, cleared only by rst
    output logic        rd_err
);

    // Beat counter is just wide enough to index every beat of a burst.
    localparam int              CNT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
    localparam logic [3:0]      AR_LEN    = 4'(BURST_BEATS - 1);
    localparam logic [2:0]      AR_SIZE   = 3'b010;   // 4 bytes per beat
    localparam logic [1:0]      AR_BURST  = 2'b01;    // INCR

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic              beat_v;
    logic              err_q;

    logic              r_hs;
    logic              last_beat;
    logic              beat_err;
    logic              unused_addr_bits;

    // Line offset bits are irrelevant: the burst always starts at the line base.
    assign unused_addr_bits = ^I_addr[3:0];

    // R handshake is derived from state rather than from RREADY so the
    // next-state logic does not loop back through its own output.
    assign r_hs      = (state == DATA) && RVALID;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Any bad response, foreign ID, or RLAST disagreeing with the beat count.
    assign beat_err  = r_hs && ((RRESP != 2'b00) ||
                                (RID != AXI_ID) ||
                                (RLAST != last_beat));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and channel outputs; AR fields read zero outside ADDR.
    always_comb begin
        state_nxt = state;
        ARVALID   = 1'b0;
        ARADDR    = 32'd0;
        ARLEN     = 4'd0;
        ARSIZE    = 3'd0;
        ARBURST   = 2'd0;
        ARID      = 4'd0;
        RREADY    = 1'b0;

        case (state)
            IDLE: begin
                if (I_req) begin
                    state_nxt = ADDR;
                end
            end

            ADDR: begin
                // addr_q is frozen while in ADDR, so the AR fields stay
                // stable for the whole time ARVALID waits on ARREADY.
                ARVALID = 1'b1;
                ARADDR  = addr_q;
                ARLEN   = AR_LEN;
                ARSIZE  = AR_SIZE;
                ARBURST = AR_BURST;
                ARID    = AXI_ID;
                if (ARREADY) begin
                    state_nxt = DATA;
                end
            end

            DATA: begin
                RREADY = 1'b1;
                // The beat count alone ends the burst; RLAST only feeds
                // the error check.
                if (r_hs && last_beat) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                // Wait for the cache to drop its request so a request still
                // held high does not refetch the same line.
                if (!I_req) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line base address captured on request acceptance.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && I_req) begin
            addr_q <= {I_addr[31:4], 4'b0000};
        end
    end

    // Beat capture, delivery pulse, beat counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= 32'd0;
            beat_cnt <= '0;
            beat_v   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            beat_v <= r_hs;

            if ((state == IDLE) && I_req) begin
                beat_cnt <= '0;
            end

            if (r_hs) begin
                data_q <= RDATA;
                // Wrap to zero only on the beat that leaves DATA.
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end

            if (beat_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign I_out  = data_q;
    assign I_wait = ~beat_v;
    assign rd_err = err_q;

endmodule
